// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction memory port, decode handshake and redirect.
// master = fetch unit; slave = memory/decode/execute environment.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            decode_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      opcode;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            misalign;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output instr_valid,
        input  decode_ready,
        output instr,
        output instr_pc,
        output opcode,
        input  branch_taken,
        input  branch_target,
        output misalign
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  instr_valid,
        output decode_ready,
        input  instr,
        input  instr_pc,
        input  opcode,
        output branch_taken,
        output branch_target,
        input  misalign
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-beat imem requests, held instruction to decode.
// Ports: clk, rst (async high), bus (master: imem req/resp, decode valid/ready, redirect).
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input logic                clk,
    input logic                rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            misalign_q;
    logic            redirect;
    logic            capture;

    assign redirect = bus.branch_taken;
    // A response is kept only when it lands in WAIT without a redirect.
    assign capture  = (state == WAIT) && bus.imem_rvalid && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ:  state_nxt = redirect ? DRAIN : WAIT;
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_nxt = redirect ? REQ : HOLD;
                end else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (redirect || bus.decode_ready) begin
                    state_nxt = REQ;
                end
            end
            // The outstanding response must come back before a new request;
            // a redirect here only replaces the pc.
            DRAIN: begin
                if (bus.imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = 1'b0;
        bus.imem_addr   = '0;
        bus.instr_valid = 1'b0;
        unique case (state)
            REQ: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = pc;
            end
            HOLD:    bus.instr_valid = 1'b1;
            default: bus.instr_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && (bus.branch_target[1:0] != 2'b00);
            if (redirect) begin
                pc <= {bus.branch_target[XLEN-1:2], 2'b00};
            end else if (capture) begin
                pc <= pc + XLEN'(PC_STEP);
            end
            if (capture) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    assign bus.instr    = instr_q;
    assign bus.instr_pc = instr_pc_q;
    assign bus.opcode   = instr_q[6:0];
    assign bus.misalign = misalign_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model with latency,
// scoreboard of accepted instructions, vector table and directed corners.
module tb_instr_fetch_unit;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

    instr_fetch_unit #(
        .XLEN    (XLEN),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        logic [6:0]  opc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    logic [31:0] mem[0:63];

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    logic        pend_active = 1'b0;
    int          pend_cnt    = 0;
    logic [31:0] pend_addr   = '0;
    logic        pend_disc   = 1'b0;
    logic        cur_disc    = 1'b1;
    logic [31:0] cur_addr    = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: scoreboard bookkeeping before the edge, memory model after.
    task automatic step();
        exp_t e;
        if (bus.imem_rvalid && !cur_disc && !bus.branch_taken && !rst) begin
            sb.push_back('{word: bus.imem_rdata, pc: cur_addr});
        end
        if (bus.branch_taken) begin
            if (pend_active) pend_disc = 1'b1;
            if (bus.instr_valid && sb.size() > 0) void'(sb.pop_front());
        end
        if (bus.instr_valid && bus.decode_ready && !bus.branch_taken) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_accept: got pc %h expected no instruction",
                         bus.instr_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", bus.instr, e.word);
                chk("sb_pc", bus.instr_pc, e.pc);
            end
        end
        @(posedge clk);
        #1;
        bus.branch_taken = 1'b0;
        bus.imem_rvalid  = 1'b0;
        if (pend_active) begin
            if (pend_cnt <= 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem[pend_addr[7:2]];
                cur_addr        = pend_addr;
                cur_disc        = pend_disc;
                pend_active     = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (bus.imem_req) begin
            pend_active = 1'b1;
            pend_cnt    = lat;
            pend_addr   = bus.imem_addr;
            pend_disc   = 1'b0;
        end
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!bus.instr_valid && n < 20) begin
            step();
            n++;
        end
        if (!bus.instr_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: instr_valid timeout got 0 expected 1", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] held;
        rst               = 1'b1;
        bus.imem_rvalid   = 1'b0;
        bus.imem_rdata    = '0;
        bus.decode_ready  = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;

        vecs[0] = '{addr: 32'h00, word: 32'h0000_0033, opc: 7'b0110011};
        vecs[1] = '{addr: 32'h04, word: 32'h0000_2083, opc: 7'b0000011};
        vecs[2] = '{addr: 32'h08, word: 32'h0010_2023, opc: 7'b0100011};
        vecs[3] = '{addr: 32'h0C, word: 32'h0000_0863, opc: 7'b1100011};
        vecs[4] = '{addr: 32'h10, word: 32'h0000_0000, opc: 7'b0000000};
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0000_0013 | (32'(i) << 7);
        end
        for (int i = 0; i < 5; i++) begin
            mem[vecs[i].addr[7:2]] = vecs[i].word;
        end
        mem[63] = 32'h0000_006F;

        step();
        step();
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_misalign", {31'b0, bus.misalign}, 32'h0);
        chk("rst_opcode", {25'b0, bus.opcode}, 32'h0);

        // first fetch at minimum latency
        rst              = 1'b0;
        lat              = 1;
        bus.decode_ready = 1'b1;
        step();
        chk("t1_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t1_addr", bus.imem_addr, 32'h0);
        step();
        chk("t1_wait_valid", {31'b0, bus.instr_valid}, 32'h0);
        step();
        chk("t1_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("t1_opcode", {25'b0, bus.opcode}, 32'h33);
        chk("t1_pc", bus.instr_pc, 32'h0);
        step();
        chk("t1_next_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t1_next_addr", bus.imem_addr, 32'h4);

        // sequential stream from the vector table
        for (int i = 1; i < 5; i++) begin
            wait_valid("t2_valid");
            chk("t2_opcode", {25'b0, bus.opcode}, {25'b0, vecs[i].opc});
            chk("t2_pc", bus.instr_pc, vecs[i].addr);
            step();
        end

        // decode stall
        bus.decode_ready = 1'b0;
        wait_valid("t3_valid");
        held = mem[5];
        chk("t3_instr", bus.instr, held);
        chk("t3_pc", bus.instr_pc, 32'h14);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_hold_instr", bus.instr, held);
            chk("t3_hold_pc", bus.instr_pc, 32'h14);
            chk("t3_hold_valid", {31'b0, bus.instr_valid}, 32'h1);
            chk("t3_hold_req", {31'b0, bus.imem_req}, 32'h0);
        end
        lat              = 3;
        bus.decode_ready = 1'b1;
        step();
        chk("t3_resume_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t3_resume_addr", bus.imem_addr, 32'h18);

        // redirect during WAIT, latency 3
        bus.decode_ready = 1'b0;
        step();
        chk("t4_wait_valid", {31'b0, bus.instr_valid}, 32'h0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        lat               = 1;
        step();
        chk("t4_misalign", {31'b0, bus.misalign}, 32'h0);
        n = 0;
        while (!bus.imem_req && n < 20) begin
            chk("t4_no_valid", {31'b0, bus.instr_valid}, 32'h0);
            step();
            n++;
        end
        chk("t4_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t4_addr", bus.imem_addr, 32'h40);
        wait_valid("t4_valid");
        chk("t4_pc", bus.instr_pc, 32'h40);
        chk("t4_opcode", {25'b0, bus.opcode}, {25'b0, mem[16][6:0]});

        // misaligned redirect in HOLD together with decode_ready
        lat               = 3;
        bus.decode_ready  = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h42;
        step();
        chk("t5_misalign", {31'b0, bus.misalign}, 32'h1);
        chk("t5_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("t5_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t5_addr", bus.imem_addr, 32'h40);
        bus.decode_ready = 1'b0;
        step();
        chk("t5_misalign_end", {31'b0, bus.misalign}, 32'h0);

        // async reset mid-WAIT, stale response lands in REQ
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req", {31'b0, bus.imem_req}, 32'h0);
        chk("t6_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("t6_instr", bus.instr, 32'h0);
        chk("t6_pc", bus.instr_pc, 32'h0);
        pend_disc = 1'b1;
        step();
        rst              = 1'b0;
        lat              = 1;
        bus.decode_ready = 1'b1;
        step();
        chk("t6_first_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t6_first_addr", bus.imem_addr, 32'h0);
        step();
        chk("t6_wait_valid", {31'b0, bus.instr_valid}, 32'h0);
        step();
        chk("t6_valid", {31'b0, bus.instr_valid}, 32'h1);
        chk("t6_opcode", {25'b0, bus.opcode}, 32'h33);
        chk("t6_ipc", bus.instr_pc, 32'h0);
        step();

        // redirect in REQ to the top of the address space, then wrap
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        step();
        chk("t7_misalign", {31'b0, bus.misalign}, 32'h0);
        wait_valid("t7_valid");
        chk("t7_pc", bus.instr_pc, 32'hFFFF_FFFC);
        chk("t7_opcode", {25'b0, bus.opcode}, 32'h6F);
        step();
        chk("t7_wrap_req", {31'b0, bus.imem_req}, 32'h1);
        chk("t7_wrap_addr", bus.imem_addr, 32'h0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_empty: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
